// File: rtl/rv_pkg.sv
// Shared constants for the integer register file and its scoreboard.
//   XLEN        data width of one architectural register
//   NREG        number of architectural registers (x0..x[NREG-1])
//   REG_ADDR_W  register address width
//   REG_X0      index of the hardwired-zero register
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);
    localparam int REG_X0     = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register. A bit is set
// when a long-latency producer (load/link) issues to that register, and cleared
// when writeback delivers the result. x0 never becomes pending.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   set_en, set_addr        mark a register as having a result in flight
//   clr_en, clr_addr        writeback has delivered the result for a register
//   rs1_addr, rs2_addr      lookup addresses
//   rs1_pending,rs2_pending raw pending bit for each lookup (no bypass masking)
module reg_scoreboard #(
    parameter int NREG = rv_pkg::NREG,
    parameter int AW   = rv_pkg::REG_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_pending,
    output logic          rs2_pending
);

    // Only x1..x[NREG-1] get a flop; x0 is spliced in as a constant zero.
    logic [NREG-1:1] pending;
    logic [NREG-1:0] pend_vec;

    // NOTE: state is updated with non-blocking assignments so every flop sees
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                // Set is tested first: a new producer issued in the same cycle
                // as the old result returns must remain outstanding.
                if (set_en && (set_addr == AW'(i))) begin
                    pending[i] <= 1'b1;
                end else if (clr_en && (clr_addr == AW'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    assign pend_vec    = {pending, 1'b0};
    assign rs1_pending = pend_vec[rs1_addr];
    assign rs2_pending = pend_vec[rs2_addr];

endmodule

// File: rtl/regfile_wb_port.sv
// Integer register file fed by the writeback stage.
//   Two zero-latency read ports for decode, one synchronous write port for
//   writeback, optional same-cycle write-to-read bypass, and a pending-write
//   scoreboard that raises a decode stall for registers still awaiting a
//   load/link result.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rs1_addr_in, rs2_addr_in        read addresses from decode
//   rs1_use_in, rs2_use_in          decode instruction really reads rsN
//   rs1_data_out, rs2_data_out      read data
//   write_data_in, rd_addr_in,
//   regWrite_in                     writeback triple
//   pend_set_in, pend_addr_in       long-latency producer issued this cycle
//   rs1_pending_out,rs2_pending_out rsN value not yet available
//   stall_out                       hold decode
module regfile_wb_port #(
    parameter int XLEN   = rv_pkg::XLEN,
    parameter int NREG   = rv_pkg::NREG,
    parameter int AW     = rv_pkg::REG_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr_in,
    input  logic [AW-1:0]   rs2_addr_in,
    input  logic            rs1_use_in,
    input  logic            rs2_use_in,
    output logic [XLEN-1:0] rs1_data_out,
    output logic [XLEN-1:0] rs2_data_out,
    input  logic [XLEN-1:0] write_data_in,
    input  logic [AW-1:0]   rd_addr_in,
    input  logic            regWrite_in,
    input  logic            pend_set_in,
    input  logic [AW-1:0]   pend_addr_in,
    output logic            rs1_pending_out,
    output logic            rs2_pending_out,
    output logic            stall_out
);

    import rv_pkg::*;

    localparam logic BYP_EN = (BYPASS != 0);

    logic [XLEN-1:0] regs [1:NREG-1];
    logic [XLEN-1:0] rs1_stored;
    logic [XLEN-1:0] rs2_stored;
    logic            wr_en;
    logic            rs1_fwd;
    logic            rs2_fwd;
    logic            rs1_pend_raw;
    logic            rs2_pend_raw;

    // Writes to x0 are architecturally discarded.
    assign wr_en = regWrite_in && (rd_addr_in != AW'(REG_X0));

    // NOTE: the array is reset because a mid-run reset must clear every
    // architectural register at once; that rules out a RAM macro here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_en && (rd_addr_in == AW'(i))) begin
                    regs[i] <= write_data_in;
                end
            end
        end
    end

    // NOTE: every combinational output gets a default before the loop, so no
    // address pattern can leave it unassigned and infer a latch.
    always_comb begin
        rs1_stored = '0;
        rs2_stored = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs1_addr_in == AW'(i)) rs1_stored = regs[i];
            if (rs2_addr_in == AW'(i)) rs2_stored = regs[i];
        end
    end

    // wr_en already excludes x0, so forwarding never makes x0 non-zero.
    assign rs1_fwd = BYP_EN && wr_en && (rd_addr_in == rs1_addr_in);
    assign rs2_fwd = BYP_EN && wr_en && (rd_addr_in == rs2_addr_in);

    // During reset the stored values are already zero; gating here also keeps
    // a writeback presented during reset from leaking through the bypass.
    always_comb begin
        rs1_data_out = '0;
        rs2_data_out = '0;
        if (rst_n) begin
            rs1_data_out = rs1_fwd ? write_data_in : rs1_stored;
            rs2_data_out = rs2_fwd ? write_data_in : rs2_stored;
        end
    end

    reg_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_en      (pend_set_in),
        .set_addr    (pend_addr_in),
        .clr_en      (regWrite_in),
        .clr_addr    (rd_addr_in),
        .rs1_addr    (rs1_addr_in),
        .rs2_addr    (rs2_addr_in),
        .rs1_pending (rs1_pend_raw),
        .rs2_pending (rs2_pend_raw)
    );

    // A result arriving this cycle resolves the hazard only if it is forwarded.
    assign rs1_pending_out = rs1_pend_raw && !rs1_fwd;
    assign rs2_pending_out = rs2_pend_raw && !rs2_fwd;
    assign stall_out       = (rs1_pending_out && rs1_use_in) ||
                             (rs2_pending_out && rs2_use_in);

endmodule
